// File: rtl/tlk2711_tx_sched_pkg.sv
// Shared word encodings and FSM state type for the TLK2711 transmit scheduler.
`default_nettype none

package tlk2711_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] D5_6    = 8'hC5;
  localparam logic [7:0] D11_5   = 8'hAB;
  localparam logic [7:0] D21_5   = 8'hB5;
  localparam logic [7:0] HDR_TAG = 8'h5A;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    IDLE = 3'd1,
    SOF  = 3'd2,
    HDR  = 3'd3,
    DATA = 3'd4,
    EOF  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tlk2711_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_CH.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        ptr,
  output logic [2:0]        grant,
  output logic              any_req
);

  logic [3:0] idx;

  always_comb begin
    grant   = 3'd0;
    any_req = 1'b0;
    idx     = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
        if (!any_req && (idx == 4'(k)) && req[k]) begin
          any_req = 1'b1;
          grant   = 3'(k);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlk2711_tx_sched.sv
// Frame scheduler sharing one TLK2711 TX link between NUM_CH sources, round-robin per frame.
`default_nettype none

module tlk2711_tx_sched
  import tlk2711_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int MIN_IDLE = 2,
  parameter int MAX_LEN  = 256
) (
  input  logic                 tx_clk,
  input  logic                 rst_n,
  input  logic                 i_link_en,
  input  logic [NUM_CH-1:0]    i_valid,
  input  logic [16*NUM_CH-1:0] i_data,
  input  logic [NUM_CH-1:0]    i_last,
  output logic [NUM_CH-1:0]    o_ready,
  output logic [15:0]          o_txd,
  output logic                 o_tkmsb,
  output logic                 o_tklsb,
  output logic                 o_enable,
  output logic                 o_busy,
  output logic [2:0]           o_grant_id
);

  localparam int IDLE_W = $clog2(MIN_IDLE + 1);
  localparam int WORD_W = $clog2(MAX_LEN + 1);

  localparam logic [15:0] COMMA_WORD = {K28_5, D5_6};
  localparam logic [15:0] SOF_WORD   = {K28_5, D11_5};
  localparam logic [15:0] EOF_WORD   = {K28_5, D21_5};

  state_t              state, state_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic [WORD_W-1:0]   word_cnt, word_cnt_nxt;
  logic [2:0]          rr_ptr, rr_ptr_nxt, grant_nxt, ptr_after;
  logic [15:0]         txd_nxt;
  logic                tkmsb_nxt, tklsb_nxt, enable_nxt, busy_nxt;
  logic [2:0]          arb_grant;
  logic                arb_any;
  logic                sel_valid, sel_last;
  logic [15:0]         sel_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (i_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // Only the granted channel is looked at while a frame is open.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 16'd0;
    o_ready   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (o_grant_id == 3'(k)) begin
        sel_valid  = i_valid[k];
        sel_last   = i_last[k];
        sel_data   = i_data[16*k +: 16];
        o_ready[k] = (state == DATA) && i_link_en;
      end
    end
  end

  assign ptr_after = (o_grant_id >= 3'(NUM_CH - 1)) ? 3'd0 : o_grant_id + 3'd1;

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    word_cnt_nxt = word_cnt;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = o_grant_id;
    txd_nxt      = COMMA_WORD;
    tkmsb_nxt    = 1'b1;
    tklsb_nxt    = 1'b0;
    enable_nxt   = 1'b1;
    busy_nxt     = 1'b0;
    case (state)
      OFF: begin
        enable_nxt   = 1'b0;
        idle_cnt_nxt = '0;
        if (i_link_en) state_nxt = IDLE;
      end
      IDLE: begin
        if (idle_cnt < IDLE_W'(MIN_IDLE)) idle_cnt_nxt = idle_cnt + 1'b1;
        if (!i_link_en) begin
          state_nxt = OFF;
        end else if ((idle_cnt >= IDLE_W'(MIN_IDLE)) && arb_any) begin
          grant_nxt = arb_grant;
          state_nxt = SOF;
        end
      end
      SOF, HDR, DATA: begin
        busy_nxt = 1'b1;
        if (!i_link_en) begin
          // Link dropped mid-frame: close the frame right away, then power down.
          txd_nxt      = EOF_WORD;
          rr_ptr_nxt   = ptr_after;
          idle_cnt_nxt = '0;
          state_nxt    = OFF;
        end else if (state == SOF) begin
          txd_nxt   = SOF_WORD;
          state_nxt = HDR;
        end else if (state == HDR) begin
          txd_nxt      = {HDR_TAG, 5'd0, o_grant_id};
          tkmsb_nxt    = 1'b0;
          word_cnt_nxt = '0;
          state_nxt    = DATA;
        end else if (sel_valid) begin
          txd_nxt      = sel_data;
          tkmsb_nxt    = 1'b0;
          word_cnt_nxt = word_cnt + 1'b1;
          if (sel_last || (word_cnt == WORD_W'(MAX_LEN - 1))) state_nxt = EOF;
        end
      end
      EOF: begin
        busy_nxt     = 1'b1;
        txd_nxt      = EOF_WORD;
        rr_ptr_nxt   = ptr_after;
        idle_cnt_nxt = '0;
        state_nxt    = i_link_en ? IDLE : OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idle_cnt   <= '0;
      word_cnt   <= '0;
      rr_ptr     <= 3'd0;
      o_grant_id <= 3'd0;
      o_txd      <= 16'd0;
      o_tkmsb    <= 1'b0;
      o_tklsb    <= 1'b0;
      o_enable   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
      rr_ptr     <= rr_ptr_nxt;
      o_grant_id <= grant_nxt;
      o_txd      <= txd_nxt;
      o_tkmsb    <= tkmsb_nxt;
      o_tklsb    <= tklsb_nxt;
      o_enable   <= enable_nxt;
      o_busy     <= busy_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlk2711_tx_sched.sv
// Randomized frame-level bench: sources feed per-channel queues, a stream parser checks framing and RR order.
`default_nettype none

module tb_tlk2711_tx_sched;

  localparam int NCH  = 3;
  localparam int MINI = 2;
  localparam int MAXL = 4;

  localparam logic [15:0] COMMA_W = 16'hBCC5;
  localparam logic [15:0] SOF_W   = 16'hBCAB;
  localparam logic [15:0] EOF_W   = 16'hBCB5;

  logic             tx_clk = 1'b0;
  logic             rst_n, link_en;
  logic [NCH-1:0]   valid, last, ready;
  logic [16*NCH-1:0] data;
  logic [15:0]      txd;
  logic             tkmsb, tklsb, enable, busy;
  logic [2:0]       grant_id;

  always #5 tx_clk = ~tx_clk;

  tlk2711_tx_sched #(.NUM_CH(NCH), .MIN_IDLE(MINI), .MAX_LEN(MAXL)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .i_link_en(link_en),
    .i_valid(valid), .i_data(data), .i_last(last), .o_ready(ready),
    .o_txd(txd), .o_tkmsb(tkmsb), .o_tklsb(tklsb), .o_enable(enable),
    .o_busy(busy), .o_grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each entry is {last, word}; src_q drives the pins, exp_q is the scoreboard copy.
  logic [16:0] src_q [NCH][$];
  logic [16:0] exp_q [NCH][$];
  int          acc_cnt [NCH];
  int          gap_at  [NCH];
  int          gap_cnt [NCH];
  bit          rand_gaps;
  logic [NCH-1:0] acc, vh1, vh2;

  bit mon_en;
  int phase;        // 0 between frames, 1 expect header, 2 in payload, 3 expect EOF
  int fr_ch, fr_dcnt, fr_fill, commas, ptr_m, exp_fill, frames_done;

  task automatic push_word(int ch, logic [15:0] w, bit l);
    src_q[ch].push_back({l, w});
    exp_q[ch].push_back({l, w});
  endtask

  task automatic push_frame(int ch, int len);
    for (int i = 0; i < len; i++) push_word(ch, 16'($urandom), i == len - 1);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < NCH; k++) if (src_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic monitor();
    logic [16:0] e;
    int g;
    if (!mon_en) return;
    check("ready_onehot", 32'($onehot0(ready)), 1);
    check("enable", enable, 1);
    case (phase)
      0: begin
        if (txd == SOF_W && tkmsb && !tklsb) begin
          check("idle_gap", commas >= MINI, 1);
          check("sof_busy", busy, 1);
          g = -1;
          for (int i = 0; i < NCH; i++)
            if (g < 0 && vh2[(ptr_m + i) % NCH]) g = (ptr_m + i) % NCH;
          check("sof_had_request", g >= 0, 1);
          fr_ch = (g < 0) ? 0 : g;
          phase = 1;
        end else begin
          check("idle_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
          check("idle_busy", busy, 0);
          commas++;
        end
      end
      1: begin
        check("hdr_word", {tkmsb, tklsb, txd}, {2'b00, 8'h5A, 8'(fr_ch)});
        check("grant_id", grant_id, fr_ch);
        check("hdr_busy", busy, 1);
        fr_dcnt = 0;
        fr_fill = 0;
        phase   = 2;
      end
      2: begin
        check("frame_busy", busy, 1);
        if (!tkmsb && !tklsb) begin
          if (exp_q[fr_ch].size() == 0) begin
            check("data_unexpected", txd, 0);
            phase = 3;
          end else begin
            e = exp_q[fr_ch].pop_front();
            check("data", txd, e[15:0]);
            fr_dcnt++;
            if (e[16] || fr_dcnt == MAXL) phase = 3;
          end
        end else begin
          check("fill_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
          fr_fill++;
        end
      end
      default: begin
        check("eof_word", {tkmsb, tklsb, txd}, {2'b10, EOF_W});
        check("eof_busy", busy, 1);
        if (exp_fill >= 0) check("fill_count", fr_fill, exp_fill);
        ptr_m  = (fr_ch + 1) % NCH;
        commas = 0;
        phase  = 0;
        frames_done++;
      end
    endcase
  endtask

  task automatic step();
    logic [16:0] h;
    bit gap;
    @(negedge tx_clk);
    monitor();
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        void'(src_q[k].pop_front());
        acc_cnt[k]++;
        if (acc_cnt[k] == gap_at[k]) gap_cnt[k] = 2;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      gap = 1'b0;
      if (gap_cnt[k] > 0) begin
        gap = 1'b1;
        gap_cnt[k]--;
      end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
        gap = 1'b1;
      end
      if (src_q[k].size() > 0 && !gap) begin
        h = src_q[k][0];
        valid[k] = 1'b1;
        data[16*k +: 16] = h[15:0];
        last[k] = h[16];
      end else begin
        valid[k] = 1'b0;
        data[16*k +: 16] = 16'($urandom);
        last[k] = 1'($urandom);
      end
    end
    vh2 = vh1;
    vh1 = valid;
    #1;
    acc = valid & ready;
  endtask

  task automatic drain(int budget, string tag);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (phase == 0) && all_empty();
    end
    check({tag, "_drain"}, done, 1);
    repeat (3) step();
  endtask

  task automatic clear_sources();
    for (int k = 0; k < NCH; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      gap_at[k]  = 0;
      gap_cnt[k] = 0;
    end
    acc = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, n;
    rst_n = 1'b0; link_en = 1'b0; valid = '0; last = '0; data = '0;
    acc = '0; vh1 = '0; vh2 = '0; rand_gaps = 1'b0;
    mon_en = 1'b0; phase = 0; commas = 0; ptr_m = 0; exp_fill = 0; frames_done = 0;
    for (int k = 0; k < NCH; k++) begin acc_cnt[k] = 0; gap_at[k] = 0; gap_cnt[k] = 0; end

    repeat (3) @(negedge tx_clk);
    check("rst_txd", txd, 0);
    check("rst_tkmsb", tkmsb, 0);
    check("rst_tklsb", tklsb, 0);
    check("rst_enable", enable, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst_n = 1'b1;

    step();
    check("off_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
    check("off_enable", enable, 0);
    link_en = 1'b1;
    step();
    check("exit_off_enable", enable, 0);
    step();
    check("idle_enable", enable, 1);
    check("idle_first_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
    check("idle_ready", ready, 0);
    mon_en = 1'b1; commas = 1; phase = 0; ptr_m = 0;
    repeat (4) step();

    // Single 3-word frame from ch0.
    f0 = frames_done;
    push_word(0, 16'h1111, 1'b0);
    push_word(0, 16'h2222, 1'b0);
    push_word(0, 16'h3333, 1'b1);
    drain(200, "t1");
    check("t1_frames", frames_done - f0, 1);

    // ch0 and ch1 contending with 1-word frames.
    f0 = frames_done;
    for (int i = 0; i < 3; i++) begin push_frame(0, 1); push_frame(1, 1); end
    drain(400, "t2");
    check("t2_frames", frames_done - f0, 6);

    // ch1 pauses for two cycles after its second word.
    f0 = frames_done;
    exp_fill = 2;
    gap_at[1] = acc_cnt[1] + 2;
    push_frame(1, 4);
    drain(200, "t3");
    check("t3_frames", frames_done - f0, 1);
    gap_at[1] = 0;

    // 6-word source frame truncated at MAX_LEN into 4 + 2.
    f0 = frames_done;
    exp_fill = 0;
    push_frame(1, 6);
    drain(200, "t4");
    check("t4_frames", frames_done - f0, 2);

    // Randomized traffic with random valid gaps.
    exp_fill = -1;
    rand_gaps = 1'b1;
    for (int i = 0; i < 40; i++) push_frame($urandom_range(0, NCH - 1), $urandom_range(1, 7));
    drain(20000, "rand");
    rand_gaps = 1'b0;
    for (int k = 0; k < NCH; k++) check("rand_leftover", exp_q[k].size(), 0);

    // Link enable dropped inside DATA.
    exp_fill = 0;
    push_frame(0, 5);
    n = 0;
    while (!(phase == 2 && fr_dcnt >= 1) && n < 100) begin step(); n++; end
    check("abort_reached_data", phase == 2 && fr_dcnt >= 1, 1);
    mon_en = 1'b0;
    link_en = 1'b0;
    #1;
    check("abort_ready", ready, 0);
    acc = '0;
    step();
    check("abort_eof", {tkmsb, tklsb, txd}, {2'b10, EOF_W});
    check("abort_eof_enable", enable, 1);
    step();
    check("abort_off_enable", enable, 0);
    check("abort_off_busy", busy, 0);
    check("abort_off_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
    clear_sources();

    // Asynchronous reset in the middle of a frame.
    link_en = 1'b1;
    repeat (5) step();
    push_frame(2, 4);
    n = 0;
    while (src_q[2].size() == 4 && n < 100) begin step(); n++; end
    check("rst_reached_data", src_q[2].size() < 4, 1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_txd", txd, 0);
    check("arst_enable", enable, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 0);
    check("arst_grant", grant_id, 0);
    clear_sources();
    step();
    check("arst_hold_txd", txd, 0);
    rst_n = 1'b1;
    step();
    check("restart_off_word", {tkmsb, tklsb, txd}, {2'b10, COMMA_W});
    check("restart_off_enable", enable, 0);
    check("restart_busy", busy, 0);
    mon_en = 1'b1; phase = 0; commas = 0; ptr_m = 0; exp_fill = 0;
    f0 = frames_done;
    push_frame(1, 2);
    push_frame(2, 2);
    drain(200, "restart");
    check("restart_frames", frames_done - f0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlk2711_tx_sched.md
Name: tlk2711_tx_sched

Overview:
- Transmit-side frame scheduler for the TLK2711 serdes TX parallel interface.
- Shares one TLK2711 TX link between NUM_CH streaming requesters using round-robin arbitration at frame granularity.
- Emits comma idles, SOF, header, payload, fill and EOF words, and drives o_txd/o_tkmsb/o_tklsb/o_enable directly.
- Sits between the per-channel packet sources and the TLK2711 pins.

Parameters:
NUM_CH, 2, number of requesting channels (1..8)
MIN_IDLE, 2, minimum comma words after enable and between EOF and the next SOF (>=1)
MAX_LEN, 256, maximum payload words per frame; reaching it forces EOF

Ports:
tx_clk  in  1  TX word clock; all logic synchronous to it
rst_n  in  1  asynchronous active-low reset
i_link_en  in  1  link enable from configuration
i_valid  in  NUM_CH  per-channel word valid
i_data  in  16*NUM_CH  per-channel word; channel k occupies [16k+15:16k]
i_last  in  NUM_CH  per-channel last word of frame
o_ready  out  NUM_CH  per-channel accept, one-hot or zero
o_txd  out  16  TLK2711 TXD
o_tkmsb  out  1  K-flag, upper byte
o_tklsb  out  1  K-flag, lower byte
o_enable  out  1  TLK2711 ENABLE
o_busy  out  1  high from SOF through EOF
o_grant_id  out  3  index of the channel owning the current frame

Behaviour:
- Reset values: o_txd=0, o_tkmsb=0, o_tklsb=0, o_enable=0, o_ready=0, o_busy=0, o_grant_id=0. RR pointer=0. State=OFF.
- Async reset asserted mid-frame: all outputs drop immediately. No EOF is sent.
- Word encodings (hi/lo bytes, tkmsb/tklsb):
  - COMMA: K28.5 0xBC / D5.6 0xC5, 1/0
  - SOF: 0xBC / D11.5 0xAB, 1/0
  - EOF: 0xBC / D21.5 0xB5, 1/0
  - HDR: 0x5A / {5'b0, channel index}, 0/0
  - DATA: payload word, 0/0
  - FILL: identical to COMMA
- Outputs are registered. The word accepted on cycle n (i_valid&o_ready) appears on o_txd at n+1.
- o_ready is combinational from state/grant: high only for the granted channel in DATA.
- States and transitions:
  - OFF: o_enable=0, o_txd=COMMA pattern, idle counter cleared. Goes to IDLE when i_link_en=1.
  - IDLE: o_enable=1, sends COMMA every cycle and counts up to MIN_IDLE. When count>=MIN_IDLE and any i_valid=1, latches the RR winner (first valid at or after the pointer, wrapping modulo NUM_CH) into o_grant_id and goes to SOF.
  - SOF: one SOF word. Goes to HDR.
  - HDR: one HDR word. Goes to DATA, with word counter=0.
  - DATA: if the granted i_valid=1, sends the word and increments the counter. If the granted i_valid=0, sends FILL; the counter is unchanged. Goes to EOF after the word with i_last=1, or after word number MAX_LEN (truncation: the remainder of that source frame is sent as a new frame later).
  - EOF: one EOF word. RR pointer becomes (grant+1) mod NUM_CH. Idle counter cleared. Goes to IDLE.
- i_link_en falls:
  - In IDLE: go to OFF next cycle.
  - In SOF/HDR/DATA: o_ready forced 0, next word is EOF, then OFF.
  - In EOF: finish EOF, then OFF.
- Non-granted channels' i_valid/i_last are ignored during a frame. i_last on a non-accepted cycle is ignored.
- NUM_CH=1: the pointer stays 0.
- Word counter width: $clog2(MAX_LEN+1).
- o_busy=1 in SOF, HDR, DATA and EOF.

Decomposition:
- Package tlk2711_pkg holds:
  - constants K28_5, D5_6, D11_5, D21_5, HDR_TAG=8'h5A
  - the state enum {OFF, IDLE, SOF, HDR, DATA, EOF}
- Sub-module rr_arbiter (NUM_CH): inputs req vector, pointer; outputs grant index and any_req. Purely combinational.

Test Plan:
- Reset, then i_link_en=1, no valid → o_enable=1 on the cycle after OFF exit, continuous 0xBCC5 with tkmsb=1, tklsb=0; o_ready=0.
- ch0 sends 3 words 0x1111/0x2222/0x3333 (last on the third) → o_txd sequence ≥2×0xBCC5, 0xBCAB, 0x5A00, 0x1111, 0x2222, 0x3333, 0xBCB5, then 0xBCC5. tkmsb pattern 1,1,0,0,0,0,1.
- ch0 and ch1 both continuously valid, 1-word frames → HDR alternates 0x5A00/0x5A01, with ≥2 commas between EOF and SOF.
- ch1 drops i_valid for 2 cycles mid-frame → two 0xBCC5 FILL words inside DATA; word count unaffected; EOF after last.
- MAX_LEN=4, source streams 6 words with last on the sixth → frame 1: 4 data words then EOF; frame 2 (same channel if alone): 2 data words then EOF.
- i_link_en falls during DATA → next word 0xBCB5, then o_enable=0. Async rst_n pulse mid-frame → outputs 0 immediately, restart in OFF.
